// File: rtl/jelly2_communication_irq_ctl_pkg.sv
// Shared register map and helpers for the communication-pipe interrupt controller.
// The top and its testbench both import these definitions.
package jelly2_communication_irq_ctl_pkg;

    localparam logic [7:0] ADR_CORE_ID      = 8'h00;
    localparam logic [7:0] ADR_CORE_VERSION = 8'h01;
    localparam logic [7:0] ADR_GLOBAL_EN    = 8'h04;
    localparam logic [7:0] ADR_SRC_RAW      = 8'h08;
    localparam logic [7:0] ADR_PENDING      = 8'h09;
    localparam logic [7:0] ADR_ENABLE       = 8'h0a;
    localparam logic [7:0] ADR_EDGE_MODE    = 8'h0b;
    localparam logic [7:0] ADR_PENDING_SET  = 8'h0c;
    localparam logic [7:0] ADR_ACTIVE       = 8'h0d;
    localparam logic [7:0] ADR_HIGHEST      = 8'h0e;

    // The HIGHEST register flags a valid index in its top data bit.
    function automatic int highest_valid_pos(input int dat_width);
        return dat_width - 32'sd1;
    endfunction

endpackage

// File: rtl/jelly2_priority_encoder_lsb.sv
// Combinational priority encoder: reports the lowest-numbered set bit of i_data.
module jelly2_priority_encoder_lsb #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_data,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_valid = |i_data;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            o_index = i_data[i] ? IDX_W'(i) : o_index;
        end
    end

endmodule

// File: rtl/jelly2_communication_irq_ctl.sv
// Wishbone interrupt controller for the communication-pipe array: latches, masks and
// prioritises pipe interrupt sources and drives one registered CPU interrupt line.
module jelly2_communication_irq_ctl
    import jelly2_communication_irq_ctl_pkg::*;
#(
    parameter int                  NUM_IRQ        = 16,
    parameter logic [31:0]         CORE_ID        = 32'h527a_f1f0,
    parameter logic [31:0]         CORE_VERSION   = 32'h0001_0000,
    parameter int                  WB_ADR_WIDTH   = 8,
    parameter int                  WB_DAT_WIDTH   = 32,
    parameter int                  WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter logic                INIT_GLOBAL_EN = 1'b0,
    parameter logic [NUM_IRQ-1:0]  INIT_ENABLE    = '0,
    parameter logic [NUM_IRQ-1:0]  INIT_EDGE      = '1
) (
    input  logic                     s_wb_clk_i,
    input  logic                     s_wb_rst_i,
    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic                     s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o,
    input  logic [NUM_IRQ-1:0]       irq_src,
    output logic                     irq
);

    localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int VLD_POS = highest_valid_pos(WB_DAT_WIDTH);

    generate
        if (NUM_IRQ < 1 || NUM_IRQ >= WB_DAT_WIDTH) begin : g_param_check
            $error("NUM_IRQ must be in 1..WB_DAT_WIDTH-1");
        end
    endgenerate

    logic [NUM_IRQ-1:0]      r_src_dly;
    logic [NUM_IRQ-1:0]      r_pending;
    logic [NUM_IRQ-1:0]      r_enable;
    logic [NUM_IRQ-1:0]      r_edge;
    logic                    r_global_en;
    logic                    r_irq;
    logic                    r_highest_valid;
    logic [IDX_W-1:0]        r_highest_index;

    logic                    w_wr;
    logic [WB_DAT_WIDTH-1:0] w_bit_mask;
    logic [NUM_IRQ-1:0]      w_wmask;
    logic [NUM_IRQ-1:0]      w_wdat;
    logic                    w_sel_pending;
    logic                    w_sel_set;
    logic                    w_sel_enable;
    logic                    w_sel_edge;
    logic                    w_sel_global;
    logic [NUM_IRQ-1:0]      w_clr;
    logic [NUM_IRQ-1:0]      w_set;
    logic [NUM_IRQ-1:0]      w_rise;
    logic [NUM_IRQ-1:0]      w_pending_next;
    logic [NUM_IRQ-1:0]      w_active;
    logic                    w_enc_valid;
    logic [IDX_W-1:0]        w_enc_index;
    logic [WB_DAT_WIDTH-1:0] w_highest_word;
    logic                    w_unused;

    assign s_wb_ack_o = s_wb_stb_i;
    assign irq        = r_irq;
    assign w_wr       = s_wb_stb_i & s_wb_we_i;

    // Expand byte-lane selects into a per-bit write mask.
    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < WB_SEL_WIDTH; i++) begin
            w_bit_mask[i*8 +: 8] = {8{s_wb_sel_i[i]}};
        end
    end

    assign w_wmask       = w_bit_mask[NUM_IRQ-1:0];
    assign w_wdat        = s_wb_dat_i[NUM_IRQ-1:0];
    assign w_sel_pending = w_wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PENDING));
    assign w_sel_set     = w_wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PENDING_SET));
    assign w_sel_enable  = w_wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_ENABLE));
    assign w_sel_edge    = w_wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_EDGE_MODE));
    assign w_sel_global  = w_wr && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_GLOBAL_EN));
    assign w_clr         = w_sel_pending ? (w_wdat & w_wmask) : '0;
    assign w_set         = w_sel_set     ? (w_wdat & w_wmask) : '0;
    assign w_rise        = irq_src & ~r_src_dly;

    // Edge bits: set (W1S or rising edge) beats W1C. Level bits mirror the source.
    assign w_pending_next = (r_edge & ((r_pending & ~w_clr) | w_set | w_rise))
                          | (~r_edge & irq_src);
    assign w_active       = r_pending & r_enable;
    assign w_unused       = ^{s_wb_dat_i, w_bit_mask};

    jelly2_priority_encoder_lsb #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_data  (w_active),
        .o_valid (w_enc_valid),
        .o_index (w_enc_index)
    );

    // Register bank, pending latch and registered interrupt outputs.
    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            r_src_dly       <= irq_src;
            r_pending       <= '0;
            r_enable        <= INIT_ENABLE;
            r_edge          <= INIT_EDGE;
            r_global_en     <= INIT_GLOBAL_EN;
            r_irq           <= 1'b0;
            r_highest_valid <= 1'b0;
            r_highest_index <= '0;
        end else begin
            r_src_dly <= irq_src;
            r_pending <= w_pending_next;
            if (w_sel_enable) begin
                r_enable <= (r_enable & ~w_wmask) | (w_wdat & w_wmask);
            end else begin
                r_enable <= r_enable;
            end
            if (w_sel_edge) begin
                r_edge <= (r_edge & ~w_wmask) | (w_wdat & w_wmask);
            end else begin
                r_edge <= r_edge;
            end
            if (w_sel_global && s_wb_sel_i[0]) begin
                r_global_en <= s_wb_dat_i[0];
            end else begin
                r_global_en <= r_global_en;
            end
            r_irq           <= r_global_en & (|w_active);
            r_highest_valid <= w_enc_valid;
            r_highest_index <= w_enc_index;
        end
    end

    // Read mux: combinational, so a same-cycle write is seen only on later reads.
    always_comb begin
        w_highest_word                = '0;
        w_highest_word[IDX_W-1:0]     = r_highest_index;
        w_highest_word[VLD_POS]       = r_highest_valid;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CORE_ID):      s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(ADR_CORE_VERSION): s_wb_dat_o = WB_DAT_WIDTH'(CORE_VERSION);
            WB_ADR_WIDTH'(ADR_GLOBAL_EN):    s_wb_dat_o = WB_DAT_WIDTH'(r_global_en);
            WB_ADR_WIDTH'(ADR_SRC_RAW):      s_wb_dat_o = WB_DAT_WIDTH'(irq_src);
            WB_ADR_WIDTH'(ADR_PENDING):      s_wb_dat_o = WB_DAT_WIDTH'(r_pending);
            WB_ADR_WIDTH'(ADR_ENABLE):       s_wb_dat_o = WB_DAT_WIDTH'(r_enable);
            WB_ADR_WIDTH'(ADR_EDGE_MODE):    s_wb_dat_o = WB_DAT_WIDTH'(r_edge);
            WB_ADR_WIDTH'(ADR_ACTIVE):       s_wb_dat_o = WB_DAT_WIDTH'(w_active);
            WB_ADR_WIDTH'(ADR_HIGHEST):      s_wb_dat_o = w_highest_word;
            default:                         s_wb_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_jelly2_communication_irq_ctl.sv
// Scoreboard testbench for jelly2_communication_irq_ctl: stimulus pushes expected read data
// and irq levels into queues; a negedge monitor pops and compares.
module tb_jelly2_communication_irq_ctl;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        ack;
    logic [15:0] src;
    logic        irq;

    logic        chk_irq;
    logic        done;
    logic        reported;
    exp_t        rd_q[$];
    exp_t        irq_q[$];
    int          n_checks;
    int          n_errors;

    jelly2_communication_irq_ctl dut (
        .s_wb_clk_i (clk),
        .s_wb_rst_i (rst),
        .s_wb_adr_i (adr),
        .s_wb_dat_i (dat_w),
        .s_wb_dat_o (dat_r),
        .s_wb_we_i  (we),
        .s_wb_sel_i (sel),
        .s_wb_stb_i (stb),
        .s_wb_ack_o (ack),
        .irq_src    (src),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        stb     = 1'b0;
        we      = 1'b0;
        chk_irq = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; dat_w = d; sel = s; we = 1'b1; stb = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.name = nm; x.val = e;
        rd_q.push_back(x);
        adr = a; we = 1'b0; stb = 1'b1;
    endtask

    task automatic xirq(input logic e, input string nm);
        exp_t x;
        x.name = nm; x.val = {31'd0, e};
        irq_q.push_back(x);
        chk_irq = 1'b1;
    endtask

    // Monitor: compares every presented read and every requested irq sample.
    always @(negedge clk) begin
        exp_t e;
        if (stb && !we) begin
            n_checks++;
            if (ack !== 1'b1) begin
                n_errors++;
                $display("FAIL ack: got %b expected 1", ack);
            end
            n_checks++;
            if (rd_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_underflow: got read of %h expected none", adr);
            end else begin
                e = rd_q.pop_front();
                if (dat_r !== e.val) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", e.name, dat_r, e.val);
                end
            end
        end
        if (chk_irq) begin
            n_checks++;
            if (irq_q.size() == 0) begin
                n_errors++;
                $display("FAIL irq_underflow: got irq %b expected none", irq);
            end else begin
                e = irq_q.pop_front();
                if (irq !== e.val[0]) begin
                    n_errors++;
                    $display("FAIL %s: got %b expected %b", e.name, irq, e.val[0]);
                end
            end
        end
        if (done && !reported) begin
            reported <= 1'b1;
            n_checks++;
            if (rd_q.size() != 0 || irq_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain: got %0d left expected 0", rd_q.size() + irq_q.size());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        done = 1'b0; reported = 1'b0; chk_irq = 1'b0;
        rst = 1'b1; adr = 8'h00; dat_w = 32'h0; we = 1'b0; sel = 4'h0; stb = 1'b0;
        src = 16'h0008;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state; src[3] held through release must not latch.
        xirq(1'b0, "irq_reset"); rd(8'h00, 32'h527a_f1f0, "core_id"); tick();
        rd(8'h01, 32'h0001_0000, "core_version"); tick();
        rd(8'h09, 32'h0, "pending_reset"); tick();
        rd(8'h0b, 32'h0000_ffff, "edge_reset"); tick();
        rd(8'h0e, 32'h0, "highest_reset"); tick();
        src = 16'h0000;
        rd(8'h09, 32'h0, "pending_no_false_edge"); tick();

        // Priority and W1C sequence.
        wr(8'h0a, 32'h0000_0028, 4'hf); tick();
        wr(8'h04, 32'h0000_0001, 4'hf); tick();
        src = 16'h0020; xirq(1'b0, "irq_src5_c0"); tick();
        src = 16'h0008; xirq(1'b0, "irq_src5_c1"); tick();
        src = 16'h0000; xirq(1'b1, "irq_src5_c2"); rd(8'h09, 32'h28, "pending_5_3"); tick();
        rd(8'h0e, 32'h8000_0003, "highest_3"); tick();
        wr(8'h09, 32'h0000_0008, 4'hf); tick();
        rd(8'h09, 32'h20, "pending_after_w1c3"); tick();
        rd(8'h0e, 32'h8000_0005, "highest_5"); xirq(1'b1, "irq_still_5"); tick();
        wr(8'h09, 32'h0000_0020, 4'hf); tick();
        xirq(1'b1, "irq_w1c_n1"); tick();
        xirq(1'b0, "irq_w1c_n2"); rd(8'h0e, 32'h0, "highest_none"); tick();

        // Rising edge and W1C in the same cycle: set wins.
        wr(8'h0a, 32'h0000_0004, 4'hf); tick();
        src = 16'h0004; wr(8'h09, 32'h0000_0004, 4'hf); tick();
        src = 16'h0000; rd(8'h09, 32'h4, "set_wins"); tick();
        rd(8'h0e, 32'h8000_0002, "highest_2"); xirq(1'b1, "irq_bit2"); tick();
        wr(8'h09, 32'h0000_0004, 4'hf); tick();
        rd(8'h09, 32'h0, "pending_clr2"); tick();
        xirq(1'b0, "irq_clr2"); tick();

        // Level mode on bit 7.
        wr(8'h0b, 32'h0000_ff7f, 4'b0011); tick();
        src = 16'h0080; rd(8'h09, 32'h0, "level_j0"); tick();
        rd(8'h09, 32'h80, "level_j1"); tick();
        wr(8'h09, 32'h0000_0080, 4'hf); tick();
        rd(8'h09, 32'h80, "level_w1c_ignored"); tick();
        src = 16'h0000; rd(8'h09, 32'h80, "level_j4"); tick();
        rd(8'h09, 32'h0, "level_j5"); tick();

        // Byte lanes, unmapped address, W1S, raw source and active views.
        wr(8'h0a, 32'h0000_ffff, 4'b0001); tick();
        rd(8'h0a, 32'h0000_00ff, "enable_bytelane"); tick();
        wr(8'h3f, 32'hffff_ffff, 4'hf); tick();
        rd(8'h3f, 32'h0, "unmapped"); tick();
        wr(8'h0c, 32'h0000_0001, 4'hf); tick();
        rd(8'h09, 32'h1, "pending_w1s"); tick();
        src = 16'h0100; rd(8'h08, 32'h100, "src_raw"); tick();
        rd(8'h09, 32'h101, "pending_edge8"); xirq(1'b1, "irq_w1s"); tick();
        rd(8'h0d, 32'h1, "active"); tick();
        rd(8'h0e, 32'h8000_0000, "highest_0"); tick();
        wr(8'h0c, 32'h0000_0080, 4'hf); tick();
        rd(8'h09, 32'h101, "w1s_level_ignored"); tick();
        rd(8'h0b, 32'h0000_ff7f, "edge_rb"); tick();
        rd(8'h04, 32'h1, "global_rb"); tick();

        // Reset mid-operation, source still high.
        rst = 1'b1; tick();
        rst = 1'b0; xirq(1'b0, "irq_rst_mid"); rd(8'h09, 32'h0, "pending_rst_mid"); tick();
        rd(8'h0a, 32'h0, "enable_rst_mid"); tick();
        rd(8'h04, 32'h0, "global_rst_mid"); tick();
        rd(8'h09, 32'h0, "pending_no_edge_mid"); tick();

        done = 1'b1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
